// File: rtl/nios_debug_sysclk_bridge.sv
// nios_debug_sysclk_bridge
//   Moves JTAG debug commands from the TCK domain into clk. The update-IR and
//   update-DR levels are synchronized and edge detected. An update-IR rise
//   captures ir_in. An update-DR rise queues {IR, sr} in a small FIFO, which
//   a clk-domain consumer drains with a valid/ready handshake.
//
// Optional feature:
//   NIOS_DEBUG_SYSCLK_DROP_CNT_EN - adds drop_count[7:0], a saturating count
//                                   of dropped pushes.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   vs_uir, vs_udr  update-IR / update-DR levels (asynchronous, TCK domain)
//   ir_in, sr       instruction and shift-register contents (TCK domain, stable)
//   cmd_valid       head-of-queue command present
//   cmd_ready       consumer accepts head command
//   cmd_ir          instruction of the head command
//   cmd_data        data of the head command
//   take_action     one-hot pulse, bit cmd_ir, in the cycle a command is popped
//   fifo_level      number of queued commands
//   overflow        sticky flag, set when a command is dropped
//   overflow_clr    clears overflow (and drop_count)
//   drop_count      saturating dropped-command count (optional)
module nios_debug_sysclk_bridge #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vs_uir,
  input  logic                        vs_udr,
  input  logic [IR_W-1:0]             ir_in,
  input  logic [DATA_W-1:0]           sr,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [IR_W-1:0]             cmd_ir,
  output logic [DATA_W-1:0]           cmd_data,
  output logic [(2**IR_W)-1:0]        take_action,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        overflow_clr
`ifdef NIOS_DEBUG_SYSCLK_DROP_CNT_EN
  ,
  output logic [7:0]                  drop_count
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int EW      = IR_W + DATA_W;
  localparam int BLANK_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic                   uir_prev, udr_prev;
  logic                   uir_rise, udr_rise;
  logic [BLANK_W-1:0]     blank_cnt;
  logic                   edges_open;
  logic [IR_W-1:0]        ir_reg;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic                   full, push, pop, push_ok, drop;

  // Edge detection stays blind until the synchronizers have filled with
  // post-reset samples. A level that is already high at release is then
  // absorbed into *_prev and is not reported as a new event.
  assign edges_open = (blank_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync  <= '0;
      udr_sync  <= '0;
      uir_prev  <= 1'b0;
      udr_prev  <= 1'b0;
      uir_rise  <= 1'b0;
      udr_rise  <= 1'b0;
      blank_cnt <= BLANK_W'(SYNC_STAGES + 1);
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_prev <= uir_sync[SYNC_STAGES-1];
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_rise <= edges_open & uir_sync[SYNC_STAGES-1] & ~uir_prev;
      udr_rise <= edges_open & udr_sync[SYNC_STAGES-1] & ~udr_prev;
      if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         ir_reg <= '0;
    else if (uir_rise) ir_reg <= ir_in;
  end

  // Queue control. Pop is gated by reset so that a flush never emits actions.
  assign cmd_valid = (level != '0);
  assign full      = (level == LW'(FIFO_DEPTH));
  assign push      = udr_rise & ~reset;
  assign pop       = cmd_valid & cmd_ready & ~reset;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {ir_reg, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign {cmd_ir, cmd_data} = mem[rd_ptr];
  assign fifo_level         = level;

  always_comb begin
    take_action = '0;
    if (pop) take_action[cmd_ir] = 1'b1;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef NIOS_DEBUG_SYSCLK_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (overflow_clr) begin
      drop_count <= '0;
    end
  end
`endif

endmodule
